fir_inverse: RTL and testbench

- Inverse (deconvolution) counterpart to the team's 2-tap FIR stage: reconstructs the original sample stream x[n] from a filtered stream y[n] = b0·x[n] + b1·x[n-1].
- Computes x[n] = g·(y[n] − b1·x[n-1]), where g = 1/b0 is supplied pre-computed in Q format.
- Uses one shared multiplier, time-multiplexed by a 4-state FSM. Sits downstream of the FIR, or in the bench as its loop-back checker.

---
 rtl/fir_inverse_if.sv | 24 ++
 rtl/fir_inverse.sv | 115 +++++++++++
 tb/tb_fir_inverse.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_inverse_if.sv
// Sample/coefficient handshake and result bundle for the inverse FIR stage.
interface fir_inverse_if #(
   parameter int W = 16
) ();
   logic                en;
   logic signed [W-1:0] Y;
   logic signed [W-1:0] g;
   logic signed [W-1:0] b1;
   logic signed [W-1:0] X;
   logic                valid;
   logic                busy;
   logic                sat;
   logic                overrun;

   modport master (
      output en, Y, g, b1,
      input  X, valid, busy, sat, overrun
   );

   modport slave (
      input  en, Y, g, b1,
      output X, valid, busy, sat, overrun
   );
endinterface

// File: rtl/fir_inverse.sv
// Inverse 2-tap FIR: x[n] = g*(y[n] - b1*x[n-1]), one shared multiplier
// time-multiplexed across a 4-state FSM (IDLE -> FB -> GAIN -> OUT).
module fir_inverse #(
   parameter int W    = 16,
   parameter int FRAC = 15
) (
   input logic        clk,
   input logic        rst,
   fir_inverse_if.slave bus
);
   localparam int PW = 2*W + 2;
   localparam int RW = PW - FRAC;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FB   = 2'd1;
   localparam logic [1:0] S_GAIN = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   logic [1:0]            r_state;
   logic signed [W-1:0]   r_y;
   logic signed [W-1:0]   r_g;
   logic signed [W-1:0]   r_b1;
   logic signed [W-1:0]   r_xprev;
   logic signed [W-1:0]   r_x;
   logic signed [W+1:0]   r_e;
   logic signed [RW-1:0]  r_r;
   logic                  r_valid;
   logic                  r_sat;
   logic                  r_ovr;

   logic signed [W-1:0]   w_ma;
   logic signed [W+1:0]   w_mb;
   logic signed [PW-1:0]  w_prod;
   logic signed [RW-1:0]  w_psh;
   logic signed [W+1:0]   w_e;
   logic                  w_hi;
   logic                  w_lo;
   logic signed [W-1:0]   w_xsat;
   logic                  w_unused;

   // Single multiplier: b1*x_prev in FB, g*e otherwise
   always_comb begin
      w_ma = r_g;
      w_mb = r_e;
      if (r_state == S_FB) begin
         w_ma = r_b1;
         w_mb = {{2{r_xprev[W-1]}}, r_xprev};
      end
   end

   assign w_prod   = PW'(w_ma) * PW'(w_mb);
   assign w_psh    = w_prod[PW-1:FRAC];
   assign w_unused = ^w_prod[FRAC-1:0];

   assign w_e = {{2{r_y[W-1]}}, r_y} - w_psh[W+1:0];

   // Out of range when the bits above the W-bit sign disagree with it
   assign w_hi   = ~r_r[RW-1] & (|r_r[RW-2:W-1]);
   assign w_lo   =  r_r[RW-1] & ~(&r_r[RW-2:W-1]);
   assign w_xsat = w_hi ? {1'b0, {(W-1){1'b1}}} :
                   w_lo ? {1'b1, {(W-1){1'b0}}} :
                          r_r[W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_y     <= '0;
         r_g     <= '0;
         r_b1    <= '0;
         r_xprev <= '0;
         r_x     <= '0;
         r_e     <= '0;
         r_r     <= '0;
         r_valid <= 1'b0;
         r_sat   <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (bus.en && r_state != S_IDLE)
            r_ovr <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (bus.en) begin
                  r_y     <= bus.Y;
                  r_g     <= bus.g;
                  r_b1    <= bus.b1;
                  r_state <= S_FB;
               end
            end
            S_FB: begin
               r_e     <= w_e;
               r_state <= S_GAIN;
            end
            S_GAIN: begin
               r_r     <= w_psh;
               r_state <= S_OUT;
            end
            S_OUT: begin
               r_x     <= w_xsat;
               r_xprev <= w_xsat;
               r_sat   <= w_hi | w_lo;
               r_valid <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.X       = r_x;
   assign bus.valid   = r_valid;
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.sat     = r_sat;
   assign bus.overrun = r_ovr;
endmodule

// File: tb/tb_fir_inverse.sv
// Directed bench for fir_inverse with an expected-result queue checked on valid.
module tb_fir_inverse;
   logic clk;
   logic rst;

   fir_inverse_if #(.W(16)) bus ();

   fir_inverse #(.W(16), .FRAC(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] x;
      logic        s;
   } exp_t;

   exp_t sbq[$];
   int   n_vec   = 0;
   int   n_err   = 0;
   int   n_valid = 0;
   int   v0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.valid === 1'b1) begin
         exp_t e;
         n_valid++;
         chk("sb_nonempty", 16'(sbq.size() != 0), 16'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("X", bus.X, e.x);
            chk("sat", 16'(bus.sat), 16'(e.s));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [15:0] y, input logic [15:0] gg,
                       input logic [15:0] b, input logic [15:0] ex,
                       input logic es);
      exp_t e;
      e.x = ex;
      e.s = es;
      sbq.push_back(e);
      bus.Y  = y;
      bus.g  = gg;
      bus.b1 = b;
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && sbq.size() != 0; i++)
         tick();
      chk("drain_timeout", 16'(sbq.size()), 16'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset with en held high
      rst    = 1'b1;
      bus.en = 1'b1;
      bus.Y  = 16'h2000;
      bus.g  = 16'h4000;
      bus.b1 = 16'h0000;
      tick();
      tick();
      rst    = 1'b0;
      bus.en = 1'b0;
      chk("rst_X", bus.X, 16'h0000);
      chk("rst_valid", 16'(bus.valid), 16'd0);
      chk("rst_busy", 16'(bus.busy), 16'd0);
      chk("rst_sat", 16'(bus.sat), 16'd0);
      chk("rst_ovr", 16'(bus.overrun), 16'd0);
      tick();
      chk("rst_no_accept", 16'(bus.busy), 16'd0);

      // 2. basic gain with latency/busy profile
      sbq.push_back('{16'h1000, 1'b0});
      bus.Y  = 16'h2000;
      bus.g  = 16'h4000;
      bus.b1 = 16'h0000;
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("lat_busy", 16'(bus.busy), 16'd1);
         chk("lat_valid", 16'(bus.valid), 16'd0);
         tick();
      end
      chk("lat_valid_k3", 16'(bus.valid), 16'd1);
      chk("lat_busy_k3", 16'(bus.busy), 16'd0);
      tick();
      chk("valid_pulse", 16'(bus.valid), 16'd0);
      chk("X_hold", bus.X, 16'h1000);
      send(16'hFFFF, 16'h4000, 16'h0000, 16'hFFFF, 1'b0);
      drain();

      // 3. feedback, b1 changed after the snapshot
      send(16'h2000, 16'h4000, 16'h0000, 16'h1000, 1'b0);
      drain();
      sbq.push_back('{16'h1400, 1'b0});
      bus.Y  = 16'h3000;
      bus.g  = 16'h4000;
      bus.b1 = 16'h4000;
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      bus.b1 = 16'h0000;
      drain();

      // 4. saturation, both polarities
      do_reset();
      send(16'h7000, 16'h7FFF, 16'h0000, 16'h6FFF, 1'b0);
      drain();
      send(16'h7000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b1);
      drain();
      tick();
      tick();
      chk("sat_hold", 16'(bus.sat), 16'd1);
      chk("satX_hold", bus.X, 16'h7FFF);
      do_reset();
      send(16'h9000, 16'h7FFF, 16'h0000, 16'h9000, 1'b0);
      drain();
      send(16'h9000, 16'h7FFF, 16'h8000, 16'h8000, 1'b1);
      drain();

      // 5. overrun
      do_reset();
      chk("ovr_clear", 16'(bus.overrun), 16'd0);
      v0 = n_valid;
      sbq.push_back('{16'h1000, 1'b0});
      bus.Y  = 16'h2000;
      bus.g  = 16'h4000;
      bus.b1 = 16'h0000;
      bus.en = 1'b1;
      tick();
      bus.Y  = 16'h7FFF;
      tick();
      bus.en = 1'b0;
      drain();
      tick();
      tick();
      tick();
      tick();
      chk("ovr_one_valid", 16'(n_valid - v0), 16'd1);
      chk("ovr_set", 16'(bus.overrun), 16'd1);
      send(16'h2000, 16'h4000, 16'h0000, 16'h1000, 1'b0);
      drain();
      chk("ovr_sticky", 16'(bus.overrun), 16'd1);

      // 6. reset mid-operation clears history
      do_reset();
      chk("ovr_rst", 16'(bus.overrun), 16'd0);
      send(16'h2000, 16'h4000, 16'h0000, 16'h1000, 1'b0);
      drain();
      tick();
      v0 = n_valid;
      bus.Y  = 16'h2000;
      bus.g  = 16'h4000;
      bus.b1 = 16'h4000;
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      chk("abort_no_valid", 16'(n_valid - v0), 16'd0);
      chk("abort_X", bus.X, 16'h0000);
      chk("abort_busy", 16'(bus.busy), 16'd0);
      send(16'h2000, 16'h4000, 16'h4000, 16'h1000, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
